// File: rtl/conv_frame_sequencer.sv
// ---------------------------------------------------------------------------
// conv_frame_sequencer
//
// Frame-level controller that sits in front of a featuremap_conv2d filter.
// It reads a WIDTH x WIDTH, 3-channel fp32 image from a show-ahead upstream
// FIFO. It wraps the image in a one-sample ring of fp32 zeros, and presents
// the resulting (WIDTH+2) x (WIDTH+2) stream through a FIFO-style interface
// (data / empty / rdreq). It also counts the filter's result pulses to
// decide when the frame is complete.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   start      one-cycle pulse that begins a frame (honoured only in IDLE)
//   in_data    upstream FIFO head {B,G,R}, valid while in_empty is low
//   in_empty   upstream FIFO empty flag
//   in_rdreq   pop request to the upstream FIFO
//   out_data   padded stream sample presented to the filter
//   out_empty  high when no padded sample is available to the filter
//   rdreq      filter read request; a sample is consumed on rdreq & ~out_empty
//   res_valid  filter result strobe, one per output pixel
//   busy       high from an accepted start until the frame completes
//   done       one-cycle pulse when the frame completes
//   frame_err  sticky error flag, cleared by reset or by an accepted start
// ---------------------------------------------------------------------------
module conv_frame_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*DATA_WIDTH-1:0] in_data,
  input  logic                    in_empty,
  output logic                    in_rdreq,
  output logic [3*DATA_WIDTH-1:0] out_data,
  output logic                    out_empty,
  input  logic                    rdreq,
  input  logic                    res_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    frame_err
);

  // Row and column span 0..WIDTH+1.
  // The result counter spans 0..WIDTH*WIDTH.
  localparam int POS_W = $clog2(WIDTH + 2);
  localparam int RES_W = $clog2(WIDTH * WIDTH + 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH + 1);
  localparam logic [RES_W-1:0] RES_MAX  = RES_W'(WIDTH * WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    DONE
  } state_t;

  state_t           state;
  logic [POS_W-1:0] row;
  logic [POS_W-1:0] col;
  logic [RES_W-1:0] res_cnt;

  logic is_pad;
  logic streaming;
  logic consume;
  logic last_pos;
  logic res_hit;
  logic res_reach;

  // Stream steering. Border positions emit a zero sample that is always
  // available, so padding never waits on the upstream FIFO. Interior
  // positions pass the FIFO head straight through. The upstream pop is
  // tied to the downstream consume, so the two happen in the same cycle
  // and the pass-through adds no latency.
  always_comb begin
    is_pad    = (row == '0) || (row == POS_LAST) ||
                (col == '0) || (col == POS_LAST);
    streaming = (state == STREAM);
    in_rdreq  = 1'b0;
    out_empty = 1'b1;
    out_data  = '0;
    if (streaming) begin
      if (is_pad) begin
        out_empty = 1'b0;
      end else begin
        out_data  = in_data;
        out_empty = in_empty;
        in_rdreq  = rdreq & ~in_empty;
      end
    end
  end

  assign consume  = streaming & rdreq & ~out_empty;
  assign last_pos = (row == POS_LAST) && (col == POS_LAST);

  // Results stop counting once a full frame's worth has arrived (saturation).
  // res_reach flags the pulse that brings the count to WIDTH*WIDTH.
  assign res_hit   = res_valid && (res_cnt != RES_MAX);
  assign res_reach = res_hit && ((res_cnt + RES_W'(1)) == RES_MAX);

  // Frame sequencer.
  // The scan position advances only on a consume, in row-major order.
  // Filter results are counted while streaming and while waiting, because
  // the filter starts producing pixels before the last padded sample has
  // been read. A full result count during streaming is an error: the
  // filter cannot legitimately finish before it has seen every input.
  // A result pulse with no frame in flight is also an error.
  // busy and done are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      res_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= STREAM;
            row       <= '0;
            col       <= '0;
            res_cnt   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
          end else if (res_valid) begin
            frame_err <= 1'b1;
          end
        end

        STREAM: begin
          if (consume) begin
            if (last_pos) begin
              state <= WAIT_RES;
            end else if (col == POS_LAST) begin
              col <= '0;
              row <= row + POS_W'(1);
            end else begin
              col <= col + POS_W'(1);
            end
          end
          if (res_hit) begin
            res_cnt <= res_cnt + RES_W'(1);
          end
          if (res_reach) begin
            frame_err <= 1'b1;
          end
        end

        WAIT_RES: begin
          if (res_hit) begin
            res_cnt <= res_cnt + RES_W'(1);
          end
          // The count may already have been reached during streaming.
          if ((res_cnt == RES_MAX) || res_reach) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          if (res_valid) begin
            frame_err <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
